// File: rtl/cmos_in_axi4s_pkg.sv
// Shared definitions for the CMOS capture AXI4-Stream output stage.
// Holds the sideband bit offsets of the coupler FIFO word (relative to the
// pixel width W), the lock state encoding and a saturating counter helper.
package cmos_in_axi4s_pkg;

  localparam int SOF_OFS = 0;
  localparam int EOL_OFS = 1;
  localparam int FLD_OFS = 2;

  typedef enum logic [0:0] {
    LOCK_WAIT = 1'b0,
    STREAM    = 1'b1
  } state_e;

  // Increment an 8-bit error counter, holding at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == 8'hFF) begin
      result = value;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cmos_in_axi4s_output_skid.sv
// axis_skid_buffer: 2-entry AXI4-Stream register slice.
// Ports:
//   clk, rst_n       - clock and asynchronous active-low reset
//   ce               - clock enable; all state frozen when low
//   s_valid, s_data  - upstream beat; the caller only asserts s_valid
//                      while s_ready is high
//   s_ready          - registered: low exactly when the spare entry is used
//   m_valid, m_data  - registered downstream beat
//   m_ready          - downstream ready
module axis_skid_buffer #(
  parameter int DW = 26
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready
);

  logic          out_valid_r;
  logic [DW-1:0] out_data_r;
  logic          skid_valid_r;
  logic [DW-1:0] skid_data_r;

  // Output entry refills from the spare entry first, so beat order is kept;
  // a new beat parks in the spare entry only while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      skid_valid_r <= 1'b0;
      skid_data_r  <= '0;
    end else if (ce) begin
      if (!out_valid_r || m_ready) begin
        if (skid_valid_r) begin
          out_data_r   <= skid_data_r;
          out_valid_r  <= 1'b1;
          skid_valid_r <= 1'b0;
        end else if (s_valid) begin
          out_data_r  <= s_data;
          out_valid_r <= 1'b1;
        end else begin
          out_valid_r <= 1'b0;
        end
      end else if (s_valid && !skid_valid_r) begin
        skid_data_r  <= s_data;
        skid_valid_r <= 1'b1;
      end
    end
  end

  assign s_ready = ~skid_valid_r;
  assign m_valid = out_valid_r;
  assign m_data  = out_data_r;

endmodule

// File: rtl/cmos_in_axi4s_output.sv
// cmos_in_axi4s_output: drains the coupler FIFO (first-word-fall-through),
// locks onto the first start-of-frame beat, maps sof/eol sideband bits to
// TUSER/TLAST, checks line length and registers the stream through a
// 2-entry skid buffer.
// Ports:
//   ACLK, ARESETN, ACLKEN            - clock, async active-low reset, enable
//   FIFO_RD_DATA/VALID, FIFO_READY   - FIFO read port {fld, eol, sof, pixel}
//   M_AXIS_VIDEO_*                   - AXI4-Stream video master
//   FIELD_ID                         - field id of the last forwarded beat
//   LOCKED                           - high while streaming
//   LINE_ERR, ERR_CNT                - framing error pulse / saturating count
//   FRAME_CNT                        - forwarded start-of-frame beats (wraps)
module cmos_in_axi4s_output #(
  parameter int C_M_AXIS_TDATA_WIDTH = 24,
  parameter int C_ACTIVE_WIDTH       = 640,
  parameter int C_LINE_CNT_WIDTH     = 12,
  parameter int C_FRAME_CNT_WIDTH    = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            ACLKEN,
  input  logic [C_M_AXIS_TDATA_WIDTH+2:0] FIFO_RD_DATA,
  input  logic                            FIFO_VALID,
  output logic                            FIFO_READY,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] M_AXIS_VIDEO_TDATA,
  output logic                            M_AXIS_VIDEO_TVALID,
  input  logic                            M_AXIS_VIDEO_TREADY,
  output logic                            M_AXIS_VIDEO_TUSER,
  output logic                            M_AXIS_VIDEO_TLAST,
  output logic                            FIELD_ID,
  output logic                            LOCKED,
  output logic                            LINE_ERR,
  output logic [7:0]                      ERR_CNT,
  output logic [C_FRAME_CNT_WIDTH-1:0]    FRAME_CNT
);

  import cmos_in_axi4s_pkg::*;

  localparam int W = C_M_AXIS_TDATA_WIDTH;
  localparam logic [C_LINE_CNT_WIDTH-1:0] LAST_BEAT = C_LINE_CNT_WIDTH'(C_ACTIVE_WIDTH - 1);
  localparam logic [C_LINE_CNT_WIDTH-1:0] CNT_ZERO  = C_LINE_CNT_WIDTH'(0);
  localparam logic [C_LINE_CNT_WIDTH-1:0] CNT_ONE   = C_LINE_CNT_WIDTH'(1);

  state_e                         state_r;
  logic [C_LINE_CNT_WIDTH-1:0]    cnt_r;
  logic                           locked_r;
  logic                           line_err_r;
  logic [7:0]                     err_cnt_r;
  logic                           field_r;
  logic [C_FRAME_CNT_WIDTH-1:0]   frame_cnt_r;

  logic                           sof_s;
  logic                           eol_s;
  logic                           fld_s;
  logic [W-1:0]                   pix_s;
  logic                           skid_ready_s;
  logic                           fifo_ready_s;
  logic                           pop_s;
  logic                           len_err_s;
  logic                           fwd_s;
  logic                           user_s;
  logic                           last_s;
  logic                           err_s;
  state_e                         state_nxt_s;
  logic [C_LINE_CNT_WIDTH-1:0]    cnt_nxt_s;
  logic [W+1:0]                   skid_out_s;

  assign sof_s = FIFO_RD_DATA[W+SOF_OFS];
  assign eol_s = FIFO_RD_DATA[W+EOL_OFS];
  assign fld_s = FIFO_RD_DATA[W+FLD_OFS];
  assign pix_s = FIFO_RD_DATA[W-1:0];

  // While unlocked the FIFO is drained freely; only a sof beat needs room in
  // the skid buffer, so it is left in the FIFO while the buffer is full.
  assign fifo_ready_s = ARESETN & ACLKEN &
                        (skid_ready_s | ((state_r == LOCK_WAIT) & ~sof_s));
  assign pop_s        = FIFO_VALID & fifo_ready_s;

  // Line length is wrong when eol and the last-beat position disagree.
  assign len_err_s = (cnt_r == LAST_BEAT) ? ~eol_s : eol_s;

  // Per-pop framing decision: forward or drop, TUSER/TLAST, error, next state.
  always_comb begin
    fwd_s       = 1'b0;
    user_s      = 1'b0;
    last_s      = 1'b0;
    err_s       = 1'b0;
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      LOCK_WAIT: begin
        if (pop_s && sof_s) begin
          fwd_s       = 1'b1;
          user_s      = 1'b1;
          cnt_nxt_s   = CNT_ONE;
          state_nxt_s = STREAM;
        end else begin
          fwd_s = 1'b0;
        end
      end
      STREAM: begin
        if (pop_s) begin
          fwd_s  = 1'b1;
          user_s = sof_s;
          if (len_err_s) begin
            // Length error dominates a coincident sof and forces TLAST.
            last_s      = 1'b1;
            err_s       = 1'b1;
            cnt_nxt_s   = CNT_ZERO;
            state_nxt_s = LOCK_WAIT;
          end else if (sof_s) begin
            last_s    = eol_s;
            err_s     = (cnt_r != CNT_ZERO);
            cnt_nxt_s = CNT_ONE;
          end else if (eol_s) begin
            last_s    = 1'b1;
            cnt_nxt_s = CNT_ZERO;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end else begin
          fwd_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = LOCK_WAIT;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Lock state, beat counter and status registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_r     <= LOCK_WAIT;
      cnt_r       <= CNT_ZERO;
      locked_r    <= 1'b0;
      line_err_r  <= 1'b0;
      err_cnt_r   <= 8'd0;
      field_r     <= 1'b0;
      frame_cnt_r <= '0;
    end else if (ACLKEN) begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      locked_r   <= (state_nxt_s == STREAM);
      line_err_r <= err_s;
      if (err_s) begin
        err_cnt_r <= sat_inc8(err_cnt_r);
      end
      if (fwd_s) begin
        field_r <= fld_s;
      end
      if (fwd_s && user_s) begin
        frame_cnt_r <= frame_cnt_r + C_FRAME_CNT_WIDTH'(1);
      end
    end
  end

  axis_skid_buffer #(
    .DW(W + 2)
  ) u_skid (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .ce      (ACLKEN),
    .s_valid (fwd_s),
    .s_data  ({user_s, last_s, pix_s}),
    .s_ready (skid_ready_s),
    .m_valid (M_AXIS_VIDEO_TVALID),
    .m_data  (skid_out_s),
    .m_ready (M_AXIS_VIDEO_TREADY)
  );

  assign FIFO_READY         = fifo_ready_s;
  assign M_AXIS_VIDEO_TUSER = skid_out_s[W+1];
  assign M_AXIS_VIDEO_TLAST = skid_out_s[W];
  assign M_AXIS_VIDEO_TDATA = skid_out_s[W-1:0];
  assign FIELD_ID           = field_r;
  assign LOCKED             = locked_r;
  assign LINE_ERR           = line_err_r;
  assign ERR_CNT            = err_cnt_r;
  assign FRAME_CNT          = frame_cnt_r;

endmodule

// File: tb/tb_cmos_in_axi4s_output.sv
// Self-checking bench for cmos_in_axi4s_output (W=8, 4-beat lines).
// A queue-based model of the output stream and status is checked every
// cycle; directed tests add hand-computed expectations.
module tb_cmos_in_axi4s_output;

  localparam int W  = 8;
  localparam int AW = 4;

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic         ACLKEN = 1'b1;
  logic [W+2:0] FIFO_RD_DATA = '0;
  logic         FIFO_VALID = 1'b0;
  logic         FIFO_READY;
  logic [W-1:0] M_AXIS_VIDEO_TDATA;
  logic         M_AXIS_VIDEO_TVALID;
  logic         M_AXIS_VIDEO_TREADY = 1'b1;
  logic         M_AXIS_VIDEO_TUSER;
  logic         M_AXIS_VIDEO_TLAST;
  logic         FIELD_ID;
  logic         LOCKED;
  logic         LINE_ERR;
  logic [7:0]   ERR_CNT;
  logic [15:0]  FRAME_CNT;

  cmos_in_axi4s_output #(
    .C_M_AXIS_TDATA_WIDTH(W),
    .C_ACTIVE_WIDTH(AW),
    .C_LINE_CNT_WIDTH(4),
    .C_FRAME_CNT_WIDTH(16)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .ACLKEN(ACLKEN),
    .FIFO_RD_DATA(FIFO_RD_DATA), .FIFO_VALID(FIFO_VALID), .FIFO_READY(FIFO_READY),
    .M_AXIS_VIDEO_TDATA(M_AXIS_VIDEO_TDATA), .M_AXIS_VIDEO_TVALID(M_AXIS_VIDEO_TVALID),
    .M_AXIS_VIDEO_TREADY(M_AXIS_VIDEO_TREADY), .M_AXIS_VIDEO_TUSER(M_AXIS_VIDEO_TUSER),
    .M_AXIS_VIDEO_TLAST(M_AXIS_VIDEO_TLAST), .FIELD_ID(FIELD_ID), .LOCKED(LOCKED),
    .LINE_ERR(LINE_ERR), .ERR_CNT(ERR_CNT), .FRAME_CNT(FRAME_CNT)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic         user;
    logic         last;
    logic [W-1:0] data;
  } beat_t;

  logic [W+2:0] fifo_q[$];
  beat_t        mq[$];
  beat_t        got_q[$];
  int           checks = 0;
  int           passed = 0;
  int           err_pulses = 0;
  int           ready_low = 0;
  int           tr_mode = 0;

  // model state (values visible after the last clock edge)
  logic         m_locked = 1'b0;
  int           m_pos = 0;
  logic         m_line_err = 1'b0;
  logic [7:0]   m_err_cnt = 8'd0;
  logic [15:0]  m_frame = 16'd0;
  logic         m_field = 1'b0;

  function automatic beat_t mk(input logic u, input logic l, input logic [W-1:0] d);
    beat_t b;
    b.user = u;
    b.last = l;
    b.data = d;
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    FIFO_VALID   = (fifo_q.size() != 0);
    FIFO_RD_DATA = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push(input logic [W-1:0] d, input logic sof, input logic eol, input logic fld);
    fifo_q.push_back({fld, eol, sof, d});
    refresh();
  endtask

  task automatic wait_drain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge ACLK); #2;
      if (fifo_q.size() == 0 && mq.size() == 0 && !M_AXIS_VIDEO_TVALID) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  // FIFO and TREADY driver: acts like a FWFT FIFO, pops on the DUT handshake
  initial begin
    logic pop_seen;
    forever begin
      @(negedge ACLK);
      pop_seen = ARESETN & FIFO_VALID & FIFO_READY & ACLKEN;
      @(posedge ACLK); #1;
      if (pop_seen && fifo_q.size() != 0) fifo_q.delete(0);
      refresh();
      case (tr_mode)
        1:       M_AXIS_VIDEO_TREADY = ~M_AXIS_VIDEO_TREADY;
        2:       M_AXIS_VIDEO_TREADY = 1'b0;
        default: M_AXIS_VIDEO_TREADY = 1'b1;
      endcase
    end
  end

  // Compare process and reference model, evaluated mid-cycle
  initial begin
    logic  exp_ready, m_err, sof, eol, fld, prev_stall;
    beat_t cur, prev_beat;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge ACLK);
      cur = {M_AXIS_VIDEO_TUSER, M_AXIS_VIDEO_TLAST, M_AXIS_VIDEO_TDATA};
      if (!ARESETN) begin
        mq.delete();
        m_locked = 1'b0; m_pos = 0; m_line_err = 1'b0;
        m_err_cnt = 8'd0; m_frame = 16'd0; m_field = 1'b0;
        prev_stall = 1'b0;
        chk("rst_tvalid", 32'(M_AXIS_VIDEO_TVALID), 32'd0);
        chk("rst_fifo_ready", 32'(FIFO_READY), 32'd0);
        chk("rst_locked", 32'(LOCKED), 32'd0);
      end else begin
        sof = FIFO_RD_DATA[W];
        eol = FIFO_RD_DATA[W+1];
        fld = FIFO_RD_DATA[W+2];
        // skid full means two beats forwarded and not yet accepted
        exp_ready = ACLKEN && (mq.size() < 2 || (!m_locked && !sof));
        chk("fifo_ready", 32'(FIFO_READY), 32'(exp_ready));
        chk("tvalid", 32'(M_AXIS_VIDEO_TVALID), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("beat", 32'(cur), 32'(mq[0]));
        if (prev_stall) chk("stall_hold", 32'(cur), 32'(prev_beat));
        chk("locked", 32'(LOCKED), 32'(m_locked));
        chk("line_err", 32'(LINE_ERR), 32'(m_line_err));
        chk("err_cnt", 32'(ERR_CNT), 32'(m_err_cnt));
        chk("frame_cnt", 32'(FRAME_CNT), 32'(m_frame));
        chk("field_id", 32'(FIELD_ID), 32'(m_field));
        if (!FIFO_READY) ready_low++;
        prev_stall = M_AXIS_VIDEO_TVALID & ~M_AXIS_VIDEO_TREADY;
        prev_beat  = cur;
        if (ACLKEN) begin
          if (LINE_ERR) err_pulses++;
          if (M_AXIS_VIDEO_TVALID && M_AXIS_VIDEO_TREADY) got_q.push_back(cur);
          if (mq.size() != 0 && M_AXIS_VIDEO_TREADY) mq.delete(0);
          m_err = 1'b0;
          if (FIFO_VALID && exp_ready) begin
            if (!m_locked) begin
              if (sof) begin
                mq.push_back(mk(1'b1, 1'b0, FIFO_RD_DATA[W-1:0]));
                m_pos = 1; m_locked = 1'b1; m_frame++; m_field = fld;
              end
            end else begin
              m_field = fld;
              // a line must end exactly on its AW-th beat
              if (eol != (m_pos == AW - 1)) begin
                mq.push_back(mk(sof, 1'b1, FIFO_RD_DATA[W-1:0]));
                m_err = 1'b1; m_locked = 1'b0; m_pos = 0;
              end else if (sof) begin
                mq.push_back(mk(1'b1, eol, FIFO_RD_DATA[W-1:0]));
                m_err = (m_pos != 0); m_pos = 1;
              end else begin
                mq.push_back(mk(1'b0, eol, FIFO_RD_DATA[W-1:0]));
                m_pos = eol ? 0 : m_pos + 1;
              end
              if (sof) m_frame++;
            end
          end
          m_line_err = m_err;
          if (m_err && m_err_cnt != 8'hFF) m_err_cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base, errb, nlast;

    // reset state
    #2;
    chk("init_tvalid", 32'(M_AXIS_VIDEO_TVALID), 32'd0);
    chk("init_tdata", 32'(M_AXIS_VIDEO_TDATA), 32'd0);
    chk("init_frame", 32'(FRAME_CNT), 32'd0);
    chk("init_ready", 32'(FIFO_READY), 32'd0);
    repeat (3) @(posedge ACLK);
    #2 ARESETN = 1'b1;

    // 1: mid-frame start, 5 beats dropped then sof locks
    base = got_q.size();
    for (int i = 1; i <= 5; i++) push(8'(i), 1'b0, 1'b0, 1'b0);
    push(8'h10, 1'b1, 1'b0, 1'b0);
    push(8'h11, 1'b0, 1'b0, 1'b0);
    push(8'h12, 1'b0, 1'b0, 1'b0);
    push(8'h13, 1'b0, 1'b1, 1'b0);
    wait_drain("t1_drain");
    chk("t1_count", 32'(got_q.size() - base), 32'd4);
    chk("t1_first", 32'(got_q[base]), 32'h210);
    chk("t1_last", 32'(got_q[base+3]), 32'h113);
    chk("t1_locked", 32'(LOCKED), 32'd1);
    chk("t1_frame", 32'(FRAME_CNT), 32'd1);

    // 2: two normal lines
    base = got_q.size();
    errb = err_pulses;
    push(8'h20, 1'b1, 1'b0, 1'b0);
    push(8'h21, 1'b0, 1'b0, 1'b0);
    push(8'h22, 1'b0, 1'b0, 1'b0);
    push(8'h23, 1'b0, 1'b1, 1'b0);
    for (int i = 4; i < 8; i++) push(8'(8'h20 + i), 1'b0, (i == 7), 1'b1);
    wait_drain("t2_drain");
    nlast = 0;
    for (int i = 0; i < 8; i++) if (got_q[base+i].last) nlast++;
    chk("t2_nlast", 32'(nlast), 32'd2);
    chk("t2_last4", 32'(got_q[base+3].last), 32'd1);
    chk("t2_last8", 32'(got_q[base+7]), 32'h127);
    chk("t2_noerr", 32'(err_pulses - errb), 32'd0);
    chk("t2_frame", 32'(FRAME_CNT), 32'd2);
    chk("t2_field", 32'(FIELD_ID), 32'd1);

    // 3: backpressure with TREADY toggling and a clock-enable gap
    base = got_q.size();
    ready_low = 0;
    tr_mode = 1;
    for (int i = 0; i < 12; i++)
      push(8'(8'h30 + i), (i == 0), (i % AW == AW - 1), 1'b0);
    repeat (3) @(posedge ACLK);
    #2 ACLKEN = 1'b0;
    repeat (3) @(posedge ACLK);
    #2 ACLKEN = 1'b1;
    wait_drain("t3_drain");
    tr_mode = 0;
    chk("t3_count", 32'(got_q.size() - base), 32'd12);
    for (int i = 0; i < 12; i++) chk("t3_order", 32'(got_q[base+i].data), 32'(8'h30 + i));
    chk("t3_ready_fell", 32'(ready_low != 0), 32'd1);
    chk("t3_frame", 32'(FRAME_CNT), 32'd3);

    // 4: early eol on beat 2, then resync on next sof
    base = got_q.size();
    errb = err_pulses;
    push(8'h40, 1'b1, 1'b0, 1'b0);
    push(8'h41, 1'b0, 1'b1, 1'b0);
    push(8'h42, 1'b0, 1'b0, 1'b0);
    push(8'h43, 1'b0, 1'b1, 1'b0);
    push(8'h50, 1'b1, 1'b0, 1'b0);
    push(8'h51, 1'b0, 1'b0, 1'b0);
    push(8'h52, 1'b0, 1'b0, 1'b0);
    push(8'h53, 1'b0, 1'b1, 1'b0);
    wait_drain("t4_drain");
    chk("t4_count", 32'(got_q.size() - base), 32'd6);
    chk("t4_early_last", 32'(got_q[base+1]), 32'h141);
    chk("t4_resync", 32'(got_q[base+2]), 32'h250);
    chk("t4_pulses", 32'(err_pulses - errb), 32'd1);
    chk("t4_err_cnt", 32'(ERR_CNT), 32'd1);
    chk("t4_frame", 32'(FRAME_CNT), 32'd5);

    // 5: missing eol on beat 4
    base = got_q.size();
    push(8'h60, 1'b1, 1'b0, 1'b0);
    push(8'h61, 1'b0, 1'b0, 1'b0);
    push(8'h62, 1'b0, 1'b0, 1'b0);
    push(8'h63, 1'b0, 1'b0, 1'b0);
    wait_drain("t5_drain");
    chk("t5_count", 32'(got_q.size() - base), 32'd4);
    chk("t5_forced_last", 32'(got_q[base+3]), 32'h163);
    chk("t5_locked", 32'(LOCKED), 32'd0);
    chk("t5_err_cnt", 32'(ERR_CNT), 32'd2);

    // 6: reset mid-line while TVALID is held by backpressure
    tr_mode = 2;
    push(8'h70, 1'b1, 1'b0, 1'b0);
    push(8'h71, 1'b0, 1'b0, 1'b0);
    push(8'h72, 1'b0, 1'b0, 1'b0);
    repeat (6) @(posedge ACLK);
    #2;
    chk("t6_pre_tvalid", 32'(M_AXIS_VIDEO_TVALID), 32'd1);
    chk("t6_pre_stalled", 32'(FIFO_READY), 32'd0);
    ARESETN = 1'b0;
    #1;
    chk("t6_rst_tvalid", 32'(M_AXIS_VIDEO_TVALID), 32'd0);
    chk("t6_rst_locked", 32'(LOCKED), 32'd0);
    chk("t6_rst_tuser", 32'(M_AXIS_VIDEO_TUSER), 32'd0);
    chk("t6_rst_frame", 32'(FRAME_CNT), 32'd0);
    fifo_q.delete();
    refresh();
    @(posedge ACLK); #2;
    ARESETN = 1'b1;
    tr_mode = 0;
    M_AXIS_VIDEO_TREADY = 1'b1;
    base = got_q.size();
    push(8'h80, 1'b0, 1'b0, 1'b0);
    push(8'h81, 1'b0, 1'b0, 1'b0);
    push(8'h90, 1'b1, 1'b0, 1'b1);
    push(8'h91, 1'b0, 1'b0, 1'b1);
    push(8'h92, 1'b0, 1'b0, 1'b1);
    push(8'h93, 1'b0, 1'b1, 1'b1);
    wait_drain("t6_drain");
    chk("t6_count", 32'(got_q.size() - base), 32'd4);
    chk("t6_first", 32'(got_q[base]), 32'h290);
    chk("t6_frame", 32'(FRAME_CNT), 32'd1);
    chk("t6_err_cnt", 32'(ERR_CNT), 32'd0);
    chk("t6_locked", 32'(LOCKED), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cmos_in_axi4s_output.md
# cmos_in_axi4s_output

Output stage of the CMOS capture path. It sits directly downstream of the native-to-AXI4-Stream FIFO coupler and drains its first-word-fall-through read port. It turns the FIFO's sideband bits into AXI4-Stream video framing (TUSER = start of frame, TLAST = end of line) and locks onto frame boundaries after reset. It also checks line length, and registers the stream through a skid buffer so it runs at full throughput under backpressure.

## Interface

Parameters:
- C_M_AXIS_TDATA_WIDTH, 24: AXIS video tdata width; equals the coupler's tdata width.
- C_ACTIVE_WIDTH, 640: beats per active line.
- C_LINE_CNT_WIDTH, 12: beat-counter width; must satisfy 2^C_LINE_CNT_WIDTH > C_ACTIVE_WIDTH.
- C_FRAME_CNT_WIDTH, 16: frame counter width.

Ports:
- ACLK, in, 1: AXI4-Stream clock, the only clock.
- ARESETN, in, 1: asynchronous, active-low reset.
- ACLKEN, in, 1: clock enable; when low, all state is frozen.
- FIFO_RD_DATA, in, C_M_AXIS_TDATA_WIDTH+3: [W+2] field id, [W+1] eol, [W] sof, [W-1:0] pixel data.
- FIFO_VALID, in, 1: FIFO data valid.
- FIFO_READY, out, 1: pop request to the FIFO.
- M_AXIS_VIDEO_TDATA, out, C_M_AXIS_TDATA_WIDTH: pixel data.
- M_AXIS_VIDEO_TVALID, out, 1: beat valid.
- M_AXIS_VIDEO_TREADY, in, 1: downstream ready.
- M_AXIS_VIDEO_TUSER, out, 1: start of frame.
- M_AXIS_VIDEO_TLAST, out, 1: end of line.
- FIELD_ID, out, 1: field id of the last forwarded beat.
- LOCKED, out, 1: high in the STREAM state.
- LINE_ERR, out, 1: one-cycle pulse per framing error.
- ERR_CNT, out, 8: count of framing errors; saturates at 255.
- FRAME_CNT, out, C_FRAME_CNT_WIDTH: count of forwarded SOF beats; wraps.

## Operation

- A pop is FIFO_VALID & FIFO_READY & ACLKEN. Exactly one FIFO word is consumed per pop.
- States are LOCK_WAIT (reset state) and STREAM.
- LOCK_WAIT:
  - FIFO_READY = ACLKEN, so the FIFO is drained.
  - Popped beats with sof=0 are discarded.
  - A beat with sof=1 is forwarded with TUSER=1; the beat counter becomes 1 and the state moves to STREAM.
- STREAM: each popped beat is forwarded and the counter increments.
  - At count == C_ACTIVE_WIDTH-1 with eol=1: the beat is forwarded with TLAST=1, the counter clears to 0 and the state stays STREAM.
  - Early eol (count < C_ACTIVE_WIDTH-1): the beat is forwarded with TLAST=1, LINE_ERR pulses, and the state moves to LOCK_WAIT.
  - Missing eol (count == C_ACTIVE_WIDTH-1, eol=0): TLAST is forced to 1, LINE_ERR pulses, and the state moves to LOCK_WAIT.
  - sof=1 while count != 0: the beat is forwarded with TUSER=1, the counter becomes 1, LINE_ERR pulses, and the state stays STREAM.
  - If sof and a line-length error coincide on the same beat, the line-length rule wins: TLAST=1, TUSER=1, one LINE_ERR pulse, state moves to LOCK_WAIT.
- FRAME_CNT increments on every forwarded beat with TUSER=1.
- FIELD_ID updates on every forwarded beat.
- ERR_CNT increments on each LINE_ERR pulse and holds at 255.

## Timing

- Reset values: TVALID, TUSER, TLAST, TDATA, FIELD_ID, LOCKED, LINE_ERR, ERR_CNT and FRAME_CNT are all 0. FIFO_READY is 0 while ARESETN is low.
- Reset asserted mid-line takes effect immediately: outputs clear, skid contents are lost, and the state returns to LOCK_WAIT.
- Latency: a beat popped in cycle n appears on TVALID in cycle n+1.
- Throughput: 1 beat/cycle while TREADY=1.
- Skid buffer: 2 entries.
  - In STREAM, FIFO_READY = ACLKEN & ~skid_full, where skid_full is a registered flag.
  - While TVALID=1 and TREADY=0, TDATA, TUSER and TLAST are held stable.
  - TVALID is never deasserted without a handshake.
- LINE_ERR is asserted in the cycle after the offending pop.
- ACLKEN=0: no pop, no output change, counters hold.

## Structure

- Shared package cmos_in_axi4s_pkg holds:
  - sideband bit offsets: SOF_OFS=0, EOL_OFS=1, FLD_OFS=2, relative to W;
  - the state enum {LOCK_WAIT, STREAM}.
- One sub-module, axis_skid_buffer: a 2-entry register slice parameterised by data width.
  - Carries TDATA, TUSER and TLAST.
  - Exposes s_ready (registered) and m_valid.

## Test plan

1. **Mid-frame start:** after reset, feed 5 beats with sof=0, then a sof beat -> 5 beats dropped with FIFO_READY=1; the first TVALID carries TUSER=1; LOCKED=1; FRAME_CNT=1.
2. **Normal lines:** C_ACTIVE_WIDTH=4; 2 lines of 4 beats, eol on each 4th beat -> TLAST on output beats 4 and 8 only; LINE_ERR never asserted.
3. **Backpressure:** continuous input with TREADY toggling 1,0,1,0 -> output sequence equals input order with no loss or duplication; TDATA stable during stalls; FIFO_READY falls only when the skid buffer is full.
4. **Early eol:** eol on beat 2 of a 4-beat line -> beat 2 has TLAST=1; LINE_ERR pulses once; ERR_CNT=1; following beats are dropped until the next sof.
5. **Missing eol:** 4th beat has eol=0 -> TLAST is forced on that beat; LINE_ERR pulses; LOCKED=0.
6. **Reset mid-line:** ARESETN=0 while TVALID=1 -> TVALID=0 and LOCKED=0 without waiting for ACLK; after release, beats are discarded until a sof beat arrives.
